axi4l_param_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register file; successor to the fixed 4-register S00_AXI slave used by the AES core IP.
- Provides NUM_WR_REGS read/write registers with byte strobes, one control/status register with a start pulse and a sticky done flag, and NUM_RD_REGS read-only status registers fed from the core.
- Returns SLVERR/DECERR responses.
- Sits between the AXI interconnect (or master VIP) and the crypto core datapath.

---
 rtl/axi4l_regfile_pkg.sv | 44 ++++
 rtl/axi4l_regfile_decode.sv | 26 ++
 rtl/axi4l_param_regfile.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_axi4l_param_regfile.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_regfile_pkg.sv
// Shared definitions for the parametrised AXI4-Lite register file:
// response codes, CTRL bit positions, FSM state types and the region decode.
package axi4l_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_DONE_BIT  = 1;
    localparam int unsigned CTRL_BUSY_BIT  = 2;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        REG_RW,
        REG_CTRL,
        REG_RO,
        REG_UNMAPPED
    } region_e;

    // Map layout: RW registers, then CTRL, then RO registers, then a hole.
    function automatic region_e decode_region(input int unsigned idx,
                                              input int unsigned num_wr,
                                              input int unsigned num_rd);
        if (idx < num_wr) begin
            return REG_RW;
        end else if (idx == num_wr) begin
            return REG_CTRL;
        end else if (idx <= num_wr + num_rd) begin
            return REG_RO;
        end
        return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/axi4l_regfile_decode.sv
// Word-index decoder shared by the read and write paths.
// Ports: idx (word index in), region_c (region type out), offset_c (index
// local to the region out; 0 for CTRL/unmapped).
module axi4l_regfile_decode
    import axi4l_regfile_pkg::*;
#(
    parameter int unsigned IDX_W       = 6,
    parameter int unsigned NUM_WR_REGS = 8,
    parameter int unsigned NUM_RD_REGS = 4
) (
    input  logic [IDX_W-1:0] idx,
    output region_e          region_c,
    output logic [IDX_W-1:0] offset_c
);

    always_comb begin
        region_c = decode_region(32'(idx), NUM_WR_REGS, NUM_RD_REGS);
        offset_c = '0;
        case (region_c)
            REG_RW:  offset_c = idx;
            REG_RO:  offset_c = IDX_W'(32'(idx) - NUM_WR_REGS - 32'd1);
            default: offset_c = '0;
        endcase
    end

endmodule

// File: rtl/axi4l_param_regfile.sv
// Parametrised AXI4-Lite slave register file for the crypto core.
// Ports: AXI4-Lite slave (S_AXI_*) on ACLK/ARESETN (sync, active-low);
// wr_regs_o = flat RW register contents, rd_regs_i = flat RO status inputs,
// start_o = one-cycle start pulse, busy_i/done_i = core status.
module axi4l_param_regfile
    import axi4l_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned NUM_WR_REGS = 8,
    parameter int unsigned NUM_RD_REGS = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [ADDR_WIDTH-1:0]             S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]             S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]             S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]             S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_WR_REGS*DATA_WIDTH-1:0] wr_regs_o,
    input  logic [NUM_RD_REGS*DATA_WIDTH-1:0] rd_regs_i,
    output logic                              start_o,
    input  logic                              busy_i,
    input  logic                              done_i
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned MAP_SIZE = NUM_WR_REGS + 1 + NUM_RD_REGS;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("axi4l_param_regfile: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_WR_REGS < 1 || NUM_RD_REGS < 1) begin : g_bad_nregs
        $error("axi4l_param_regfile: NUM_WR_REGS and NUM_RD_REGS must be >= 1");
    end
    if (64'(MAP_SIZE) > (64'(1) << IDX_W)) begin : g_bad_map
        $error("axi4l_param_regfile: register map does not fit in the address space");
    end

    wr_state_e                        w_state_q, w_state_d;
    rd_state_e                        r_state_q, r_state_d;
    logic                             aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
    logic [IDX_W-1:0]                 aw_idx_q;
    logic [DATA_WIDTH-1:0]            wdata_q;
    logic [STRB_W-1:0]                wstrb_q;
    logic                             awready_q, awready_d, wready_q, wready_d;
    logic                             bvalid_q, bvalid_d;
    logic [1:0]                       bresp_q, bresp_d;
    logic                             arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]                       rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]            rdata_q, rdata_d;
    logic                             start_q, start_d, done_q;
    logic [NUM_WR_REGS*DATA_WIDTH-1:0] wr_regs_q;

    logic                             aw_hs_c, w_hs_c, ar_hs_c;
    logic [IDX_W-1:0]                 w_idx_c, r_idx_c, w_off_c, r_off_c;
    logic [DATA_WIDTH-1:0]            wdata_c, rdata_c;
    logic [STRB_W-1:0]                wstrb_c;
    logic [1:0]                       rresp_c;
    logic                             rw_we_c, done_clr_c, start_req_c, clr_req_c;
    region_e                          w_region_c, r_region_c;

    assign aw_hs_c = S_AXI_AWVALID && awready_q;
    assign w_hs_c  = S_AXI_WVALID && wready_q;
    assign ar_hs_c = S_AXI_ARVALID && arready_q;

    // A channel that handshakes in the commit cycle is used directly, otherwise its latched copy.
    assign w_idx_c = aw_lat_q ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wdata_c = w_lat_q ? wdata_q : S_AXI_WDATA;
    assign wstrb_c = w_lat_q ? wstrb_q : S_AXI_WSTRB;
    assign r_idx_c = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

    assign start_req_c = wstrb_c[0] && wdata_c[CTRL_START_BIT];
    assign clr_req_c   = wstrb_c[0] && wdata_c[CTRL_DONE_BIT];

    axi4l_regfile_decode #(
        .IDX_W      (IDX_W),
        .NUM_WR_REGS(NUM_WR_REGS),
        .NUM_RD_REGS(NUM_RD_REGS)
    ) u_wdec (
        .idx     (w_idx_c),
        .region_c(w_region_c),
        .offset_c(w_off_c)
    );

    axi4l_regfile_decode #(
        .IDX_W      (IDX_W),
        .NUM_WR_REGS(NUM_WR_REGS),
        .NUM_RD_REGS(NUM_RD_REGS)
    ) u_rdec (
        .idx     (r_idx_c),
        .region_c(r_region_c),
        .offset_c(r_off_c)
    );

    // Write FSM: collect AW and W independently, commit once both are present.
    always_comb begin
        w_state_d  = w_state_q;
        aw_lat_d   = aw_lat_q;
        w_lat_d    = w_lat_q;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        start_d    = 1'b0;
        rw_we_c    = 1'b0;
        done_clr_c = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_lat_d = aw_lat_q || aw_hs_c;
                w_lat_d  = w_lat_q || w_hs_c;
                if (aw_lat_d && w_lat_d) begin
                    w_state_d = W_RESP;
                    aw_lat_d  = 1'b0;
                    w_lat_d   = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = RESP_OKAY;
                    case (w_region_c)
                        REG_RW: begin
                            if (busy_i) begin
                                bresp_d = RESP_SLVERR;
                            end else begin
                                rw_we_c = 1'b1;
                            end
                        end
                        REG_CTRL: begin
                            done_clr_c = clr_req_c;
                            if (start_req_c) begin
                                if (busy_i) begin
                                    bresp_d = RESP_SLVERR;
                                end else begin
                                    start_d = 1'b1;
                                end
                            end
                        end
                        REG_RO:  bresp_d = RESP_SLVERR;
                        default: bresp_d = RESP_DECERR;
                    endcase
                end else begin
                    awready_d = !aw_lat_d;
                    wready_d  = !w_lat_d;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write-side state, register array and DONE flag.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            aw_lat_q  <= 1'b0;
            w_lat_q   <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_regs_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_lat_q  <= aw_lat_d;
            w_lat_q   <= w_lat_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            start_q   <= start_d;
            if (aw_hs_c) begin
                aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs_c) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            // A new done pulse outranks a simultaneous write-1-clear.
            if (done_i) begin
                done_q <= 1'b1;
            end else if (done_clr_c) begin
                done_q <= 1'b0;
            end
            for (int k = 0; k < NUM_WR_REGS; k++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (rw_we_c && w_off_c == IDX_W'(k) && wstrb_c[b]) begin
                        wr_regs_q[k*DATA_WIDTH + b*8 +: 8] <= wdata_c[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read mux over the current register/status values.
    always_comb begin
        rdata_c = '0;
        rresp_c = RESP_OKAY;
        case (r_region_c)
            REG_RW: begin
                for (int k = 0; k < NUM_WR_REGS; k++) begin
                    if (r_off_c == IDX_W'(k)) begin
                        rdata_c = wr_regs_q[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            REG_CTRL: begin
                rdata_c[CTRL_DONE_BIT] = done_q;
                rdata_c[CTRL_BUSY_BIT] = busy_i;
            end
            REG_RO: begin
                for (int k = 0; k < NUM_RD_REGS; k++) begin
                    if (r_off_c == IDX_W'(k)) begin
                        rdata_c = rd_regs_i[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            default: rresp_c = RESP_DECERR;
        endcase
    end

    // Read FSM: one outstanding read, response captured at AR handshake.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = rdata_c;
                    rresp_d   = rresp_c;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_regs_o     = wr_regs_q;
    assign start_o       = start_q;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi4l_param_regfile.sv
// Directed bench for axi4l_param_regfile: a vector table of single
// transactions plus hand-written multi-cycle sequences.
module tb_axi4l_param_regfile;
    import axi4l_regfile_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 8;
    localparam int unsigned NWR = 8;
    localparam int unsigned NRD = 4;

    logic                ACLK = 1'b0;
    logic                ARESETN = 1'b0;
    logic [AW-1:0]       S_AXI_AWADDR = '0;
    logic [2:0]          S_AXI_AWPROT = '0;
    logic                S_AXI_AWVALID = 1'b0;
    logic                S_AXI_AWREADY;
    logic [DW-1:0]       S_AXI_WDATA = '0;
    logic [DW/8-1:0]     S_AXI_WSTRB = '0;
    logic                S_AXI_WVALID = 1'b0;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY = 1'b0;
    logic [AW-1:0]       S_AXI_ARADDR = '0;
    logic [2:0]          S_AXI_ARPROT = '0;
    logic                S_AXI_ARVALID = 1'b0;
    logic                S_AXI_ARREADY;
    logic [DW-1:0]       S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY = 1'b0;
    logic [NWR*DW-1:0]   wr_regs_o;
    logic [NRD*DW-1:0]   rd_regs_i = '0;
    logic                start_o;
    logic                busy_i = 1'b0;
    logic                done_i = 1'b0;

    always #5 ACLK = ~ACLK;

    axi4l_param_regfile #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_WR_REGS(NWR),
        .NUM_RD_REGS(NRD)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARPROT (S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .wr_regs_o    (wr_regs_o),
        .rd_regs_i    (rd_regs_i),
        .start_o      (start_o),
        .busy_i       (busy_i),
        .done_i       (done_i)
    );

    int total = 0;
    int bad = 0;
    int start_cnt = 0;

    always @(negedge ACLK) begin
        if (start_o) start_cnt++;
    end

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          busy;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input bit busy, input logic [1:0] resp,
                                input logic [31:0] rdata);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
        v.busy = busy; v.resp = resp; v.rdata = rdata;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Write with optional per-channel delays; reports BRESP and cycles from
    // the later handshake to BVALID.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output int lat, output bit early);
        bit aw_pend = 1'b1;
        bit w_pend = 1'b1;
        bit aw_fire, w_fire;
        int c = 0;
        early = 1'b0;
        while ((aw_pend || w_pend) && c < 100) begin
            if (aw_pend && c >= aw_dly) begin
                S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
            end
            if (w_pend && c >= w_dly) begin
                S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
            end
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            if (S_AXI_BVALID) early = 1'b1;
            @(posedge ACLK); #1;
            c++;
            if (aw_fire) begin aw_pend = 1'b0; S_AXI_AWVALID = 1'b0; end
            if (w_fire) begin w_pend = 1'b0; S_AXI_WVALID = 1'b0; end
        end
        check("aw_w_accepted", {aw_pend, w_pend}, 2'b00);
        lat = 0;
        while (!S_AXI_BVALID && lat < 20) begin
            @(posedge ACLK); #1;
            lat++;
        end
        resp = S_AXI_BRESP;
        @(posedge ACLK); #1;
        check("b_held", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, resp});
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        bit fired = 1'b0;
        int c = 0;
        S_AXI_ARADDR = addr;
        S_AXI_ARVALID = 1'b1;
        while (!fired && c < 100) begin
            fired = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            c++;
        end
        S_AXI_ARVALID = 1'b0;
        check("ar_accepted", fired, 1'b1);
        lat = 0;
        while (!S_AXI_RVALID && lat < 20) begin
            @(posedge ACLK); #1;
            lat++;
        end
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        @(posedge ACLK); #1;
        check("r_held", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, resp, data});
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          lat;
        bit          early;
        int          s0;
        logic [31:0] reg3;

        rd_regs_i = {32'h2468ACE0, 32'h13579BDF, 32'h0BADF00D, 32'hCAFEBABE};
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_outputs",
              {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
               S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, start_o}, '0);
        check("reset_regs", wr_regs_o, '0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        for (int k = 0; k < 8; k++) add(1, 8'(k*4), 32'(k+1), 4'hF, 0, RESP_OKAY, 0);
        for (int k = 0; k < 8; k++) add(0, 8'(k*4), 0, 0, 0, RESP_OKAY, 32'(k+1));
        add(1, 8'h00, 32'hFFFFFFFF, 4'hF,    0, RESP_OKAY,   0);
        add(1, 8'h00, 32'h12345678, 4'b0101, 0, RESP_OKAY,   0);
        add(0, 8'h00, 0, 0,                  0, RESP_OKAY,   32'hFF34FF78);
        add(1, 8'h04, 32'hDEADBEEF, 4'hF,    1, RESP_SLVERR, 0);
        add(0, 8'h04, 0, 0,                  1, RESP_OKAY,   32'h2);
        add(0, 8'h20, 0, 0,                  1, RESP_OKAY,   32'h4);
        add(1, 8'h24, 32'h11111111, 4'hF,    0, RESP_SLVERR, 0);
        add(0, 8'h24, 0, 0,                  0, RESP_OKAY,   32'hCAFEBABE);
        add(0, 8'h30, 0, 0,                  0, RESP_OKAY,   32'h2468ACE0);
        add(1, 8'h34, 32'h22222222, 4'hF,    0, RESP_DECERR, 0);
        add(0, 8'h34, 0, 0,                  0, RESP_DECERR, 0);
        add(0, 8'hFC, 0, 0,                  0, RESP_DECERR, 0);
        add(0, 8'h1E, 0, 0,                  0, RESP_OKAY,   32'h8);
        add(1, 8'h1F, 32'h000000A5, 4'b0001, 0, RESP_OKAY,   0);
        add(0, 8'h1C, 0, 0,                  0, RESP_OKAY,   32'h000000A5);

        foreach (vecs[i]) begin
            busy_i = vecs[i].busy;
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, resp, lat, early);
                check($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d_blat", i), lat, 0);
            end else begin
                do_read(vecs[i].addr, rd, resp, lat);
                check($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
                check($sformatf("v%0d_rlat", i), lat, 0);
            end
            busy_i = 1'b0;
        end
        reg3 = wr_regs_o[3*DW +: DW];
        check("wr_regs_o_reg3", reg3, 32'h4);

        // AW leads W by three cycles, then W leads AW by three cycles.
        do_write(8'h08, 32'hA1A2A3A4, 4'hF, 0, 3, resp, lat, early);
        check("aw_first_resp", resp, RESP_OKAY);
        check("aw_first_lat", lat, 0);
        check("aw_first_early_b", early, 1'b0);
        check("aw_first_single_b", S_AXI_BVALID, 1'b0);
        do_write(8'h10, 32'hB1B2B3B4, 4'hF, 3, 0, resp, lat, early);
        check("w_first_resp", resp, RESP_OKAY);
        check("w_first_lat", lat, 0);
        check("w_first_early_b", early, 1'b0);
        check("w_first_single_b", S_AXI_BVALID, 1'b0);
        do_read(8'h08, rd, resp, lat);
        check("aw_first_data", rd, 32'hA1A2A3A4);
        do_read(8'h10, rd, resp, lat);
        check("w_first_data", rd, 32'hB1B2B3B4);

        // Start pulse, then start refused while busy.
        s0 = start_cnt;
        do_write(8'h20, 32'h1, 4'h1, 0, 0, resp, lat, early);
        check("start_resp", resp, RESP_OKAY);
        check("start_pulses", start_cnt - s0, 1);
        busy_i = 1'b1;
        do_write(8'h20, 32'h1, 4'h1, 0, 0, resp, lat, early);
        busy_i = 1'b0;
        check("start_busy_resp", resp, RESP_SLVERR);
        check("start_busy_pulses", start_cnt - s0, 1);

        // DONE set, read, write-1-clear.
        done_i = 1'b1;
        @(posedge ACLK); #1;
        done_i = 1'b0;
        do_read(8'h20, rd, resp, lat);
        check("ctrl_done_set", rd, 32'h2);
        do_write(8'h20, 32'h2, 4'h1, 0, 0, resp, lat, early);
        check("ctrl_clr_resp", resp, RESP_OKAY);
        do_read(8'h20, rd, resp, lat);
        check("ctrl_done_cleared", rd, 32'h0);

        // done_i coincident with the clearing commit: DONE must survive.
        check("coinc_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        S_AXI_AWADDR = 8'h20; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'h1; S_AXI_WVALID = 1'b1;
        done_i = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; done_i = 1'b0;
        check("coinc_b", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, RESP_OKAY});
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        do_read(8'h20, rd, resp, lat);
        check("coinc_done_kept", rd, 32'h2);

        // Read and write to the same register in the same cycle.
        check("same_cycle_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        S_AXI_AWADDR = 8'h14; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 8'h14; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("same_cycle_r", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, RESP_OKAY, 32'h6});
        check("same_cycle_b", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, RESP_OKAY});
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        do_read(8'h14, rd, resp, lat);
        check("same_cycle_after", rd, 32'h55);

        // Reset while a write response is pending.
        S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("rst_pending_b", S_AXI_BVALID, 1'b1);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        check("rst_bvalid_drop", S_AXI_BVALID, 1'b0);
        check("rst_regs_zero", wr_regs_o, '0);
        ARESETN = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_no_late_b", S_AXI_BVALID, 1'b0);
        do_read(8'h00, rd, resp, lat);
        check("rst_reg0", rd, 32'h0);
        do_read(8'h20, rd, resp, lat);
        check("rst_ctrl", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
